// File: rtl/branch_redirect_unit.sv
// Resolves executed branches/jumps, compares against the fetch prediction and issues a held
// redirect (1 cycle after accept) plus flush pulse; execute is stalled while a redirect waits on fetch.
module branch_redirect_unit #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             br_valid,
  output logic             br_ready,
  input  logic [1:0]       br_kind,
  input  logic [XLEN-1:0]  br_pc,
  input  logic [XLEN-1:0]  br_imm,
  input  logic [XLEN-1:0]  br_rs1,
  input  logic             br_cmp_result,
  input  logic             br_pred_taken,
  input  logic [XLEN-1:0]  br_pred_target,
  output logic             redir_valid,
  input  logic             redir_ready,
  output logic [XLEN-1:0]  redir_pc,
  output logic             flush,
  output logic             misalign,
  output logic [CNT_W-1:0] stat_branches,
  output logic [CNT_W-1:0] stat_mispredicts
);

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_HOLD = 1'b1
  } state_e;

  localparam logic [1:0]       KIND_BR   = 2'b00;
  localparam logic [1:0]       KIND_JALR = 2'b10;
  localparam logic [1:0]       KIND_RSV  = 2'b11;
  localparam logic [XLEN-1:0]  INSN_BYTES = XLEN'(4);
  localparam logic [CNT_W-1:0] CNT_MAX   = '1;

  state_e           state_q, state_d;
  logic [XLEN-1:0]  redir_pc_q, redir_pc_d;
  logic             flush_q, flush_d;
  logic             misalign_q, misalign_d;
  logic [CNT_W-1:0] stat_br_q, stat_br_d;
  logic [CNT_W-1:0] stat_mp_q, stat_mp_d;

  logic             accept;
  logic             taken;
  logic             mispredict;
  logic             tgt_misaligned;
  logic [XLEN-1:0]  base;
  logic [XLEN-1:0]  target_raw;
  logic [XLEN-1:0]  target;
  logic [XLEN-1:0]  seq_pc;
  logic [XLEN-1:0]  actual_pc;

  // Ready depends only on registered state so execute never sees a combinational path from fetch.
  assign br_ready    = (state_q == ST_IDLE);
  assign redir_valid = (state_q == ST_HOLD);
  assign redir_pc    = redir_pc_q;
  assign flush       = flush_q;
  assign misalign    = misalign_q;
  assign stat_branches    = stat_br_q;
  assign stat_mispredicts = stat_mp_q;

  assign accept = br_valid && br_ready;

  always_comb begin
    base       = (br_kind == KIND_JALR) ? br_rs1 : br_pc;
    target_raw = base + br_imm;
    target     = (br_kind == KIND_JALR) ? {target_raw[XLEN-1:1], 1'b0} : target_raw;
    seq_pc     = br_pc + INSN_BYTES;
    taken      = (br_kind == KIND_BR) ? br_cmp_result : 1'b1;
    actual_pc  = taken ? target : seq_pc;
    // A correctly predicted not-taken branch ignores whatever target fetch guessed.
    mispredict = (taken != br_pred_taken) || (taken && (target != br_pred_target));
    tgt_misaligned = taken && target[1];
  end

  always_comb begin
    state_d    = state_q;
    redir_pc_d = redir_pc_q;
    flush_d    = 1'b0;
    misalign_d = 1'b0;
    stat_br_d  = stat_br_q;
    stat_mp_d  = stat_mp_q;

    case (state_q)
      ST_IDLE: begin
        if (accept && (br_kind != KIND_RSV)) begin
          if (stat_br_q != CNT_MAX) begin
            stat_br_d = stat_br_q + 1'b1;
          end
          if (tgt_misaligned) begin
            misalign_d = 1'b1;
          end else if (mispredict) begin
            state_d    = ST_HOLD;
            redir_pc_d = actual_pc;
            flush_d    = 1'b1;
            if (stat_mp_q != CNT_MAX) begin
              stat_mp_d = stat_mp_q + 1'b1;
            end
          end
        end
      end
      ST_HOLD: begin
        if (redir_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      redir_pc_q <= '0;
      flush_q    <= 1'b0;
      misalign_q <= 1'b0;
      stat_br_q  <= '0;
      stat_mp_q  <= '0;
    end else begin
      state_q    <= state_d;
      redir_pc_q <= redir_pc_d;
      flush_q    <= flush_d;
      misalign_q <= misalign_d;
      stat_br_q  <= stat_br_d;
      stat_mp_q  <= stat_mp_d;
    end
  end

endmodule

// File: doc/branch_redirect_unit.md
Name: branch_redirect_unit

Overview:
- Consumes the resolved branch-condition bit from the execute-stage comparator, together with branch/jump operands and the fetch-stage prediction.
- Decides the actual next PC and detects mispredictions.
- On a mispredict, issues a held redirect to fetch over a valid/ready handshake, plus a one-cycle flush pulse.
- Sits between execute and the fetch PC mux. Also keeps saturating branch/mispredict statistics counters.

Parameters:
- XLEN, 32, datapath/PC width
- CNT_W, 16, width of each statistics counter

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- br_valid  in  1  execute presents a resolved control-flow instruction
- br_ready  out  1  unit can accept this cycle
- br_kind  in  2  00 cond branch, 01 JAL, 10 JALR, 11 reserved
- br_pc  in  XLEN  PC of the instruction
- br_imm  in  XLEN  sign-extended immediate
- br_rs1  in  XLEN  rs1 value (JALR base)
- br_cmp_result  in  1  comparator output (taken condition for kind 00)
- br_pred_taken  in  1  fetch prediction: taken
- br_pred_target  in  XLEN  fetch predicted target
- redir_valid  out  1  redirect request to fetch
- redir_ready  in  1  fetch accepts redirect
- redir_pc  out  XLEN  corrected next PC
- flush  out  1  one-cycle pulse: kill younger instructions
- misalign  out  1  one-cycle pulse: taken target not 4-byte aligned
- stat_branches  out  CNT_W  accepted kinds 00/01/10
- stat_mispredicts  out  CNT_W  mispredicts that produced a redirect

Behaviour:
- Reset (synchronous, rst=1 at clk edge): state IDLE; redir_valid=0, redir_pc=0, flush=0, misalign=0, both counters=0. br_ready=1 in the first cycle after reset.
- Reset mid-HOLD: the redirect is dropped; redir_valid=0 the next cycle.
- States:
  - IDLE: br_ready=1.
  - HOLD: br_ready=0. br_ready is a function of registered state only.
- Accept occurs when br_valid && br_ready at a clock edge. All evaluation uses values sampled at that edge.
- Taken/target evaluation:
  - taken = br_cmp_result for kind 00; taken = 1 for kinds 01/10.
  - target = br_pc + br_imm for kinds 00/01; (br_rs1 + br_imm) with bit0 cleared for kind 10.
  - Adds are mod 2^XLEN and wrap silently.
  - actual = taken ? target : br_pc + 4.
- mispredict = (taken != br_pred_taken) || (taken && target != br_pred_target). Not-taken with pred not-taken is never a mispredict, whatever br_pred_target is.
- Kind 11: accepted and ignored. No counters change, no outputs.
- Misaligned target (taken && target[1]=1):
  - misalign=1 for exactly the cycle after accept.
  - No redirect, no flush, stat_mispredicts unchanged. Stays in IDLE.
- Mispredict with aligned target:
  - Cycle after accept: redir_valid=1, redir_pc=actual, flush=1 for that one cycle only, state HOLD.
  - Latency: exactly 1 cycle from accept.
- HOLD:
  - redir_valid and redir_pc are held stable until redir_ready=1 at an edge.
  - On that edge, return to IDLE; redir_valid=0 the next cycle.
  - redir_ready while redir_valid=0 is ignored.
- Correct prediction: no outputs; stays in IDLE, so back-to-back accepts are allowed every cycle.
- Simultaneous events: a br_valid arriving during HOLD (including the handshake cycle) is not accepted. The earliest new accept is the cycle after redir_valid falls.
- Counters:
  - stat_branches increments on accept of kinds 00/01/10, including misaligned ones.
  - stat_mispredicts increments on entry to HOLD.
  - Both saturate at 2^CNT_W−1.

Test Plan:
1. Cond branch, pc=0x100, imm=0x20, cmp_result=1, pred_taken=0. Expect: 1 cycle later redir_valid=1, redir_pc=0x120, flush=1 for 1 cycle; stat_mispredicts=1. Hold redir_ready=0 for 3 cycles: redir_pc stays 0x120, br_ready=0. redir_ready=1: redir_valid=0 the next cycle, br_ready=1.
2. Cond branch, pc=0x200, cmp_result=0, pred_taken=0, pred_target=0xDEAD. Expect no redirect/flush; stat_branches increments. Then cond branch, pc=0x300, imm=0x40, cmp_result=0, pred_taken=1, pred_target=0x340 → redir_pc=0x304.
3. JALR, rs1=0x1003, imm=0x4, pred_taken=1, pred_target=0x1000 → target 0x1006 has bit1=1: misalign pulse 1 cycle, no redirect. Then rs1=0x1001, imm=0x4, pred_target=0x1004 → no redirect. Then pred_target=0x2000 → redir_pc=0x1004.
4. Four back-to-back correctly predicted JALs, br_valid held high → accepted on 4 consecutive cycles; stat_branches=4. Kind 11 interleaved → counters unchanged.
5. rst asserted during HOLD with redir_ready=0 → next cycle redir_valid=0, counters=0, br_ready=1.
6. Saturation with CNT_W=4: 17 mispredicts, each redirect accepted → stat_mispredicts=15. Wrap case pc=0xFFFFFFF0, imm=0x20, taken, mispredicted → redir_pc=0x00000010.
